gate_vector_sequencer: RTL and testbench
========================================

GATE_VECTOR_SEQUENCER -- requirements
Module: gate_vector_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; every port other than clk and rst_n SHALL be synchronous to clk.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- SETTLE_CYCLES, 2, cycles each vector is held before y is sampled (legal range 1..15).
- EXPECT, 8'h7F, expected y per vector index i (bit i); the default is the 3-input NAND truth table.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, request a full truth-table run.
- abort, in, 1, synchronous abandon of the run in progress.
- y, in, 1, output of the gate under test.
- a / b / c, out, 1 each, gate stimulus; {a,b,c} = vector index, with a as MSB.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle pulse marking a completed run.
- pass, out, 1, last completed run had zero mismatches.
- observed, out, 8, sampled y per vector index.
- mismatch_cnt, out, 4, number of failing vectors (0..8).
- first_fail_idx, out, 3, lowest failing vector index.
- fail_valid, out, 1, first_fail_idx is meaningful.

Function
REQ-004 The FSM SHALL have four states: IDLE, DRIVE, SAMPLE and DONE.
REQ-005 In IDLE, start=1 SHALL cause the following on the next edge:
- idx=0 and {a,b,c}=3'b000;
- observed, mismatch_cnt, fail_valid and first_fail_idx cleared;
- busy=1 and pass=0;
- transition to DRIVE.
REQ-006 start SHALL be ignored in every state other than IDLE.
REQ-007 DRIVE SHALL hold the current vector for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-008 SAMPLE SHALL last one cycle, with the vector still driven, and on its closing edge SHALL:
- write y into observed[idx];
- if y != EXPECT[idx], increment mismatch_cnt;
- if that is the first mismatch of the run, set first_fail_idx=idx and fail_valid=1.
REQ-009 Leaving SAMPLE with idx<7, the block SHALL increment idx, drive the new vector and return to DRIVE; with idx==7 it SHALL go to DONE.
REQ-010 In DONE the block SHALL do the following for exactly one cycle, then return to IDLE:
- done=1;
- busy=0;
- pass=(mismatch_cnt==0).
REQ-011 Each vector SHALL occupy SETTLE_CYCLES+1 cycles, and done SHALL assert 8*(SETTLE_CYCLES+1)+1 cycles after the edge that samples start (25 cycles at the default).
REQ-012 In IDLE, {a,b,c} SHALL be 3'b000.
REQ-013 observed, mismatch_cnt, first_fail_idx, fail_valid and pass SHALL hold their values until the next accepted start.
REQ-014 abort=1 in DRIVE, SAMPLE or DONE SHALL cause the following on the next edge:
- return to IDLE with busy=0 and {a,b,c}=0;
- no done pulse;
- pass=0;
- results keep their partial values.
REQ-015 abort SHALL take priority over the SAMPLE capture in the same cycle, so that vector is not recorded.
REQ-016 abort=1 in IDLE SHALL have no effect; if start=1 and abort=1 arrive together in IDLE, start SHALL win.
REQ-017 mismatch_cnt SHALL saturate at 8 by construction and SHALL never wrap.
REQ-018 y SHALL be sampled only in SAMPLE; y is ignored in all other states.

Reset
REQ-019 While rst_n=0, the block SHALL immediately force:
- state=IDLE and idx=0;
- a=b=c=0;
- busy=0, done=0, pass=0;
- observed=8'h00, mismatch_cnt=0, first_fail_idx=0, fail_valid=0.
REQ-020 Reset asserted mid-run SHALL abandon the run with no done pulse; after rst_n deasserts, the block SHALL accept start on the first clock edge.

Structure
REQ-021 A shared package gate_test_pkg SHALL hold:
- the state enumeration;
- NUM_VECTORS=8;
- the default truth tables (NAND3=8'h7F, AND3=8'h80, OR3=8'hFE, NOR3=8'h01).
REQ-022 The settle countdown SHALL be a sub-module, settle_timer, with inputs load and count value and output expired; all other logic SHALL be in gate_vector_sequencer.

Verification
REQ-023 Ideal NAND3 model on y, default parameters, pulse start → the bench SHALL see:
- vectors 000..111 each for 3 cycles;
- done 25 cycles after start;
- observed=8'h7F, mismatch_cnt=0, pass=1, fail_valid=0.
REQ-024 y tied to 1, default EXPECT → observed=8'hFF, mismatch_cnt=1, first_fail_idx=7, fail_valid=1, pass=0.
REQ-025 y=~a (inverted-input fault), default EXPECT → observed=8'h0F, mismatch_cnt=3, first_fail_idx=4, pass=0.
REQ-026 abort pulsed in SAMPLE of vector 3 → the bench SHALL see:
- IDLE on the next edge, with no done pulse;
- observed bits 0..2 written and bit 3 unwritten;
- a subsequent start runs a clean full pass.
REQ-027 rst_n driven low mid-DRIVE of vector 5 → immediately busy=0, {a,b,c}=0, all results cleared; start re-pulsed during a run has no effect on timing.
REQ-028 SETTLE_CYCLES=1 with the ideal NAND3 model → each vector held 2 cycles, done 17 cycles after start, pass=1.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate vector sequencer: FSM states, vector count
// and the reference truth tables for common 3-input gates.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned SETTLE_W    = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_VECTORS);

  // Truth tables: bit i is the expected output for input vector {a,b,c} == i
  localparam logic [NUM_VECTORS-1:0] NAND3 = 8'h7F;
  localparam logic [NUM_VECTORS-1:0] AND3  = 8'h80;
  localparam logic [NUM_VECTORS-1:0] OR3   = 8'hFE;
  localparam logic [NUM_VECTORS-1:0] NOR3  = 8'h01;

  // Saturating increment so the failure count can never wrap
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter that reports when a loaded settle interval has elapsed.
// expired is high in the final cycle of the interval.
module settle_timer
  import gate_test_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] value,
  output logic                expired
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - SETTLE_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Walks a 3-input gate through all eight input vectors, samples its output
// after a settle interval and scores the result against a truth table.
module gate_vector_sequencer
  import gate_test_pkg::*;
#(
  parameter int unsigned               SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0]    EXPECT        = NAND3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   y,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] observed,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic [IDX_W-1:0]       first_fail_idx,
  output logic                   fail_valid
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic             timer_load;
  logic             expired;
  logic             accept;
  logic             cancel;
  logic             capture;
  logic             miss;

  assign accept  = (state == IDLE) && start;
  assign cancel  = (state != IDLE) && abort;
  // An abort in SAMPLE wins over the capture, so the vector is never recorded
  assign capture = (state == SAMPLE) && !abort;
  assign miss    = (y != EXPECT[idx]);

  settle_timer u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .value   (SETTLE_W'(SETTLE_CYCLES - 1)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = DRIVE;
          timer_load = 1'b1;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (expired) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          state_next = DRIVE;
          timer_load = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Vector index: only advances on a committed sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (accept || cancel) begin
      idx <= '0;
    end else if (capture && idx != LAST_IDX) begin
      idx <= idx + IDX_W'(1);
    end else if (state == DONE) begin
      idx <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      observed       <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      fail_valid     <= 1'b0;
    end else if (accept) begin
      observed       <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      fail_valid     <= 1'b0;
    end else if (capture) begin
      observed[idx] <= y;
      if (miss) begin
        mismatch_cnt <= sat_inc(mismatch_cnt);
        if (!fail_valid) begin
          first_fail_idx <= idx;
          fail_valid     <= 1'b1;
        end
      end
    end
  end

  // pass is decided on the edge entering DONE, folding in the last sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass <= 1'b0;
    end else if (accept || cancel) begin
      pass <= 1'b0;
    end else if (capture && idx == LAST_IDX) begin
      pass <= (mismatch_cnt == '0) && !miss;
    end
  end

  assign busy      = (state == DRIVE) || (state == SAMPLE);
  assign done      = (state == DONE);
  assign {a, b, c} = busy ? idx : '0;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Scoreboard bench: stimulus pushes expected run results, monitors pop and
// compare them whenever a sequencer pulses done.
module tb_gate_vector_sequencer;
  import gate_test_pkg::*;

  typedef struct {
    logic [7:0] obs;
    logic [3:0] cnt;
    logic [2:0] ffi;
    logic       fv;
    logic       pass;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic y0, y1;
  logic a0, b0, c0, busy0, done0, pass0, fv0;
  logic a1, b1, c1, busy1, done1, pass1, fv1;
  logic [7:0] obs0, obs1;
  logic [3:0] cnt0, cnt1;
  logic [2:0] ffi0, ffi1;
  int mode = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc0 = 0, start_cyc1 = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  logic [2:0] tr0[$], tr1[$];
  logic pbusy0 = 1'b0, pbusy1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate models: 0 ideal NAND3, 1 stuck-at-1, 2 output follows ~a
  assign y0 = (mode == 0) ? ~(a0 & b0 & c0) : (mode == 1) ? 1'b1 : ~a0;
  assign y1 = ~(a1 & b1 & c1);

  gate_vector_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .y(y0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .observed(obs0), .mismatch_cnt(cnt0), .first_fail_idx(ffi0), .fail_valid(fv0)
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(1), .EXPECT(NAND3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .y(y1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .observed(obs1), .mismatch_cnt(cnt1), .first_fail_idx(ffi1), .fail_valid(fv1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Vector k of the trace must equal k/(s+1) across all eight vectors
  function automatic logic [31:0] seq_ok(input logic [2:0] tr[$], input int s);
    if (tr.size() != 8 * (s + 1)) return 32'd0;
    for (int k = 0; k < tr.size(); k++)
      if (tr[k] != 3'(k / (s + 1))) return 32'd0;
    return 32'd1;
  endfunction

  always @(negedge clk) begin
    if (busy0 && !pbusy0) tr0.delete();
    if (busy0) tr0.push_back({a0, b0, c0});
    pbusy0 = busy0;
    if (done0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL s2_unexpected_done: done=1 with no run expected at cycle %0d", cyc);
      end else begin
        e0 = q0.pop_front();
        chk("s2_observed", obs0, e0.obs);
        chk("s2_mismatch_cnt", cnt0, e0.cnt);
        chk("s2_first_fail_idx", ffi0, e0.ffi);
        chk("s2_fail_valid", fv0, e0.fv);
        chk("s2_pass", pass0, e0.pass);
        chk("s2_busy_in_done", busy0, 0);
        chk("s2_done_latency", cyc - start_cyc0 + 1, e0.lat);
        chk("s2_vector_sequence", seq_ok(tr0, 2), 1);
      end
    end
  end

  always @(negedge clk) begin
    if (busy1 && !pbusy1) tr1.delete();
    if (busy1) tr1.push_back({a1, b1, c1});
    pbusy1 = busy1;
    if (done1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL s1_unexpected_done: done=1 with no run expected at cycle %0d", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("s1_observed", obs1, e1.obs);
        chk("s1_mismatch_cnt", cnt1, e1.cnt);
        chk("s1_fail_valid", fv1, e1.fv);
        chk("s1_pass", pass1, e1.pass);
        chk("s1_done_latency", cyc - start_cyc1 + 1, e1.lat);
        chk("s1_vector_sequence", seq_ok(tr1, 1), 1);
      end
    end
  end

  task automatic run0(input exp_t e, input bit push, input bit with_abort);
    @(negedge clk);
    start0 = 1'b1;
    abort0 = with_abort;
    @(posedge clk);
    #1;
    start_cyc0 = cyc;
    start0 = 1'b0;
    abort0 = 1'b0;
    if (push) q0.push_back(e);
  endtask

  task automatic wait_done(input bit which, input int lim, input string name);
    int n = 0;
    while (n < lim) begin
      @(negedge clk);
      n++;
      if ((which ? done1 : done0) === 1'b1) break;
    end
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, lim);
    end
    @(negedge clk);
  endtask

  task automatic wait_vec0(input logic [2:0] v, input int lim);
    int n = 0;
    while (n < lim) begin
      @(negedge clk);
      n++;
      if ({a0, b0, c0} == v && busy0) break;
    end
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL wait_vector_timeout: vector %0d not seen within %0d cycles", v, lim);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_pass"}, pass0, 0);
    chk({tag, "_abc"}, {a0, b0, c0}, 0);
    chk({tag, "_observed"}, obs0, 0);
    chk({tag, "_mismatch_cnt"}, cnt0, 0);
    chk({tag, "_first_fail_idx"}, ffi0, 0);
    chk({tag, "_fail_valid"}, fv0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ideal NAND3, then results must hold and an idle abort must not disturb them
    mode = 0;
    run0('{obs: 8'h7F, cnt: 4'd0, ffi: 3'd0, fv: 1'b0, pass: 1'b1, lat: 25}, 1'b1, 1'b0);
    wait_done(1'b0, 60, "nand_ideal");
    repeat (3) @(negedge clk);
    chk("hold_pass", pass0, 1);
    chk("hold_observed", obs0, 8'h7F);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("idle_abort_busy", busy0, 0);
    chk("idle_abort_pass", pass0, 1);

    // y stuck at 1: only vector 7 disagrees with NAND3
    mode = 1;
    run0('{obs: 8'hFF, cnt: 4'd1, ffi: 3'd7, fv: 1'b1, pass: 1'b0, lat: 25}, 1'b1, 1'b0);
    wait_done(1'b0, 60, "stuck_one");

    // y = ~a: vectors 4,5,6 fail
    mode = 2;
    run0('{obs: 8'h0F, cnt: 4'd3, ffi: 3'd4, fv: 1'b1, pass: 1'b0, lat: 25}, 1'b1, 1'b0);
    wait_done(1'b0, 60, "inverted_a");

    // Abort in the SAMPLE cycle of vector 3
    mode = 0;
    run0('{obs: 8'h00, cnt: 4'd0, ffi: 3'd0, fv: 1'b0, pass: 1'b0, lat: 0}, 1'b0, 1'b0);
    wait_vec0(3'd3, 40);
    @(negedge clk);
    @(negedge clk);
    abort0 = 1'b1;
    @(posedge clk);
    #1;
    abort0 = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_abc", {a0, b0, c0}, 0);
    chk("abort_done", done0, 0);
    chk("abort_pass", pass0, 0);
    chk("abort_observed", obs0, 8'h07);
    chk("abort_mismatch_cnt", cnt0, 0);
    repeat (6) @(negedge clk);
    run0('{obs: 8'h7F, cnt: 4'd0, ffi: 3'd0, fv: 1'b0, pass: 1'b1, lat: 25}, 1'b1, 1'b0);
    wait_done(1'b0, 60, "after_abort");

    // start and abort together in IDLE: start wins; a mid-run start is ignored
    run0('{obs: 8'h7F, cnt: 4'd0, ffi: 3'd0, fv: 1'b0, pass: 1'b1, lat: 25}, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(1'b0, 60, "start_abort_together");

    // Reset in DRIVE of vector 5 after failures have been recorded
    mode = 2;
    run0('{obs: 8'h00, cnt: 4'd0, ffi: 3'd0, fv: 1'b0, pass: 1'b0, lat: 0}, 1'b0, 1'b0);
    wait_vec0(3'd5, 40);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("midrun_reset");
    mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start_cyc0 = cyc;
    start0 = 1'b0;
    chk("restart_first_edge_busy", busy0, 1);
    q0.push_back('{obs: 8'h7F, cnt: 4'd0, ffi: 3'd0, fv: 1'b0, pass: 1'b1, lat: 25});
    repeat (7) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(1'b0, 60, "after_reset");

    // Shortest settle: two cycles per vector
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start_cyc1 = cyc;
    start1 = 1'b0;
    q1.push_back('{obs: 8'h7F, cnt: 4'd0, ffi: 3'd0, fv: 1'b0, pass: 1'b1, lat: 17});
    wait_done(1'b1, 40, "settle1");

    repeat (3) @(negedge clk);
    chk("s2_queue_drained", q0.size(), 0);
    chk("s1_queue_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
